ebus_writer: RTL and testbench

- Driving end of the ebus_i interface: owns and writes Q (choice) and I (integer) through a new driver modport.
- Replaces hierarchical writes from the top level with a clocked, flow-controlled writer.
- Accepts write requests over a valid/ready port and buffers them in a small FIFO.
- Applies each request to the bus and holds it for a guaranteed minimum dwell, so modport-mp readers see stable values.

---
 rtl/ebus_pkg.sv | 13 +
 rtl/ebus_i.sv | 12 +
 rtl/ebus_req_fifo.sv | 68 ++++++
 rtl/ebus_writer.sv | 121 ++++++++++++
 tb/tb_ebus_writer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ebus_pkg.sv
// Shared types for the ebus: choice encoding and the writer request payload.
package ebus_pkg;

   typedef enum logic {Y, N} choice_t;

   localparam bit TRUE = 1'b1;

   typedef struct packed {
      choice_t            q;
      logic signed [31:0] i;
   } ebus_req_t;

endpackage

// File: rtl/ebus_i.sv
// ebus signal bundle: mp is the reader view, drv is the single writer view.
interface ebus_i;

   typedef ebus_pkg::choice_t choice_t;

   choice_t            Q;
   logic signed [31:0] I;

   modport mp  (input  Q, input  I);
   modport drv (output Q, output I);

endinterface

// File: rtl/ebus_req_fifo.sv
// Request FIFO for ebus_writer; a power-of-2 depth lets the pointers wrap naturally.
module ebus_req_fifo
   import ebus_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = ebus_req_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  T                       din,
   output T                       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   T              mem_q [DEPTH];
   T              mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer, occupancy and storage update
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + LW'(do_push) - LW'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: occupancy decides what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ebus_writer.sv
// Flow-controlled driver of ebus_i: queues Q/I writes and holds each on the bus for HOLD_CYCLES.
// Optional EBUS_WRITER_DEDUP_EN drops popped entries equal to the current bus value.
module ebus_writer
   import ebus_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  choice_t                req_choice,
   input  logic signed [31:0]     req_data,
   ebus_i.drv                     bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            updates
);

   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef EBUS_WRITER_DEDUP_EN
   localparam bit DEDUP_EN = TRUE;
`else
   localparam bit DEDUP_EN = !TRUE;
`endif

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state_q, state_d;
   logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
   choice_t            q_q, q_d;
   logic signed [31:0] i_q, i_d;
   logic [15:0]        updates_q, updates_d;

   ebus_req_t fifo_din, fifo_dout, cur;
   logic      push, pop, take, full, empty;

   assign fifo_din  = '{q: req_choice, i: req_data};
   assign cur       = '{q: q_q, i: i_q};
   assign req_ready = !full;
   assign push      = req_valid && !full;

   ebus_req_fifo #(
      .DEPTH (DEPTH),
      .T     (ebus_req_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Next state: pop when idle or when the dwell expires, so back-to-back entries have no bubble
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      q_d        = q_q;
      i_d        = i_q;
      updates_d  = updates_q;
      pop        = 1'b0;
      take       = 1'b0;

      case (state_q)
         IDLE: take = !empty;
         HOLD: begin
            if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - HW'(1);
            end else if (!empty) begin
               take = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         pop = 1'b1;
         if (DEDUP_EN && (fifo_dout == cur)) begin
            state_d = IDLE;
         end else begin
            q_d        = fifo_dout.q;
            i_d        = fifo_dout.i;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
            state_d    = HOLD;
            if (updates_q != 16'hFFFF) begin
               updates_d = updates_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         q_q        <= Y;
         i_q        <= '0;
         updates_q  <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         q_q        <= q_d;
         i_q        <= i_d;
         updates_q  <= updates_d;
      end
   end

   assign bus.Q   = q_q;
   assign bus.I   = i_q;
   assign busy    = (state_q == HOLD) || !empty;
   assign updates = updates_q;

endmodule

// File: tb/tb_ebus_writer.sv
// Directed bench for ebus_writer (DEPTH=4, HOLD_CYCLES=3); honours EBUS_WRITER_DEDUP_EN.
module tb_ebus_writer;
   import ebus_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLD  = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid;
   logic               req_ready;
   choice_t            req_choice;
   logic signed [31:0] req_data;
   logic               busy;
   logic [2:0]         level;
   logic [15:0]        updates;

   int          checks   = 0;
   int          failures = 0;
   logic [32:0] log_q[$];
   logic [15:0] last_upd = '0;

   ebus_i bus_if();

   ebus_writer #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_choice (req_choice),
      .req_data   (req_data),
      .bus        (bus_if),
      .busy       (busy),
      .level      (level),
      .updates    (updates)
   );

   always #5 clk = ~clk;

   // Log the bus value every time the update counter advances
   always @(negedge clk) begin
      if (updates > last_upd) log_q.push_back({bus_if.Q, bus_if.I});
      last_upd = updates;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk("idle_timeout", 64'(busy), 64'(0));
   endtask

   task automatic push_one(input choice_t c, input int d);
      req_valid  = 1'b1;
      req_choice = c;
      req_data   = 32'(d);
      step();
      req_valid  = 1'b0;
   endtask

   initial begin
      int          base;
      int          n;
      bit          saw_full;
      logic [32:0] e;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_choice = Y;
      req_data   = '0;

      // Reset values
      step(3);
      chk("rst_q",       64'(bus_if.Q),  64'(Y));
      chk("rst_i",       64'(bus_if.I),  64'(0));
      chk("rst_ready",   64'(req_ready), 64'(1));
      chk("rst_busy",    64'(busy),      64'(0));
      chk("rst_level",   64'(level),     64'(0));
      chk("rst_updates", 64'(updates),   64'(0));
      rst = 1'b0;

      // Single request: visible one edge after acceptance
      push_one(N, 42);
      chk("single_level", 64'(level),    64'(1));
      chk("single_preq",  64'(bus_if.Q), 64'(Y));
      step();
      chk("single_q",       64'(bus_if.Q), 64'(N));
      chk("single_i",       64'(bus_if.I), 64'(42));
      chk("single_updates", 64'(updates),  64'(1));
      step(2);
      chk("single_busy_hold", 64'(busy), 64'(1));
      step();
      chk("single_busy_drop", 64'(busy),     64'(0));
      chk("single_keep_i",    64'(bus_if.I), 64'(42));

      // Back-to-back: changes exactly HOLD cycles apart
      req_valid = 1'b1; req_choice = N; req_data = 32'd1; step();
      req_choice = Y; req_data = 32'd2; step();
      req_choice = N; req_data = 32'd3; step();
      req_valid = 1'b0;
      chk("b2b_first_i", 64'(bus_if.I), 64'(1));
      chk("b2b_level",   64'(level),    64'(2));
      step();
      chk("b2b_still_1", 64'(bus_if.I), 64'(1));
      step();
      chk("b2b_second_q", 64'(bus_if.Q), 64'(Y));
      chk("b2b_second_i", 64'(bus_if.I), 64'(2));
      step(2);
      chk("b2b_still_2", 64'(bus_if.I), 64'(2));
      step();
      chk("b2b_third_i",  64'(bus_if.I), 64'(3));
      chk("b2b_updates",  64'(updates),  64'(4));
      wait_idle();

      // Backpressure with pointer wrap over 10 requests
      base     = log_q.size();
      saw_full = 1'b0;
      for (int k = 0; k < 10; k++) begin
         req_valid  = 1'b1;
         req_choice = (k % 2 == 0) ? N : Y;
         req_data   = 32'(100 + k);
         n = 0;
         while (!req_ready && n < 50) begin
            chk("bp_full_level", 64'(level), 64'(DEPTH));
            saw_full = 1'b1;
            step();
            n++;
         end
         chk("bp_ready", 64'(req_ready), 64'(1));
         step();
      end
      req_valid = 1'b0;
      wait_idle();
      chk("bp_saw_full", 64'(saw_full), 64'(1));
      chk("bp_count", 64'(log_q.size() - base), 64'(10));
      for (int k = 0; k < 10; k++) begin
         e[32]   = (k % 2 == 0);
         e[31:0] = 32'(100 + k);
         if (base + k < log_q.size()) chk("bp_entry", 64'(log_q[base + k]), 64'(e));
         else chk("bp_entry_missing", 64'(0), 64'(e));
      end
      chk("bp_updates", 64'(updates), 64'(14));

      // Reset mid-HOLD with two entries queued (plus a request during reset)
      req_valid = 1'b1; req_choice = N; req_data = 32'd500; step();
      req_choice = Y; req_data = 32'd501; step();
      req_choice = N; req_data = 32'd502; step();
      chk("mid_i",     64'(bus_if.I), 64'(500));
      chk("mid_level", 64'(level),    64'(2));
      req_choice = N; req_data = 32'd999;
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 1'b0;
      chk("mrst_q",       64'(bus_if.Q),  64'(Y));
      chk("mrst_i",       64'(bus_if.I),  64'(0));
      chk("mrst_level",   64'(level),     64'(0));
      chk("mrst_busy",    64'(busy),      64'(0));
      chk("mrst_ready",   64'(req_ready), 64'(1));
      chk("mrst_updates", 64'(updates),   64'(0));
      step(8);
      chk("mrst_after_i",       64'(bus_if.I), 64'(0));
      chk("mrst_after_updates", 64'(updates),  64'(0));

      // Duplicate entries
      req_valid = 1'b1; req_choice = N; req_data = 32'd7; step();
      step();
      req_valid = 1'b0;
      chk("dup_first_i", 64'(bus_if.I), 64'(7));
      step(2);
      chk("dup_busy_mid", 64'(busy), 64'(1));
      step();
`ifdef EBUS_WRITER_DEDUP_EN
      chk("dup_updates", 64'(updates), 64'(1));
      chk("dup_skip_idle", 64'(busy), 64'(0));
`else
      chk("dup_updates", 64'(updates), 64'(2));
      step(2);
      chk("dup_held", 64'(busy), 64'(1));
      step();
      chk("dup_release", 64'(busy), 64'(0));
`endif
      chk("dup_q", 64'(bus_if.Q), 64'(N));
      chk("dup_i", 64'(bus_if.I), 64'(7));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
